// File: rtl/ltssm_pkg.sv
// Shared LTSSM types and constants for the Detect substate logic.
package ltssm_pkg;

   typedef enum logic [2:0] {
      QUIET   = 3'd0,
      ACTIVE  = 3'd1,
      WAIT    = 3'd2,
      ACTIVE2 = 3'd3,
      DONE    = 3'd4
   } detect_sm_e;

   // 12 ms at 100 MHz
   localparam int DETECT_12MS_CYC  = 1_200_000;
   localparam int DETECT_NUM_LANES = 4;

endpackage

// File: rtl/control_detect_if.sv
// PHY-side receiver-detect handshake and electrical-idle status for Detect.
interface control_detect_if #(
   parameter int NUM_LANES = 4
);
   logic                 rxdet_req;
   logic                 rxdet_ack;
   logic [NUM_LANES-1:0] rxdet_result;
   logic [NUM_LANES-1:0] rx_elec_idle;

   modport master (
      output rxdet_req,
      input  rxdet_ack,
      input  rxdet_result,
      input  rx_elec_idle
   );

   modport slave (
      input  rxdet_req,
      output rxdet_ack,
      output rxdet_result,
      output rx_elec_idle
   );
endinterface

// File: rtl/cycle_timer.sv
// Up-counter that pulses expire_o on the cycle the count reaches LIMIT_CYC-1.
module cycle_timer #(
   parameter int LIMIT_CYC = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);
   localparam int W = (LIMIT_CYC > 2) ? $clog2(LIMIT_CYC) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT_CYC - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && !clr_i && (cnt_q == LAST);

   // Self-clearing on expiry, so the counter never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = expire_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/control_detect.sv
// Detect.Quiet / Detect.Active controller: receiver-detect handshake with the
// PHY and second-detect qualification of partial lane results.
module control_detect
   import ltssm_pkg::*;
#(
   parameter int NUM_LANES   = DETECT_NUM_LANES,
   parameter int TIMEOUT_CYC = DETECT_12MS_CYC
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 detect_en_i,
   control_detect_if.master     phy,
   output logic [NUM_LANES-1:0] lanes_w_detected_load_o,
   output logic                 detect_exit_polling_o,
   output logic [2:0]           detect_state_o
);
   detect_sm_e           state_q;
   logic [NUM_LANES-1:0] lanes_q;
   logic                 exit_q;
   logic                 timer_run;
   logic                 timer_expire;
   logic                 res_all;
   logic                 res_none;
   logic                 any_active;

   // Timer is held at zero outside the counting states, so every entry into
   // QUIET or WAIT starts from a fresh count without a loop through state_d.
   assign timer_run  = detect_en_i && (state_q == QUIET || state_q == WAIT);
   assign res_all    = &phy.rxdet_result;
   assign res_none   = ~|phy.rxdet_result;
   assign any_active = ~&phy.rx_elec_idle;

   cycle_timer #(
      .LIMIT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (timer_run),
      .clr_i    (!timer_run),
      .expire_o (timer_expire)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= QUIET;
         lanes_q <= '0;
         exit_q  <= 1'b0;
      end else begin
         exit_q <= 1'b0;
         if (!detect_en_i) begin
            state_q <= QUIET;
            lanes_q <= '0;
         end else begin
            unique case (state_q)
               QUIET: begin
                  if (timer_expire || any_active)
                     state_q <= ACTIVE;
               end
               ACTIVE: begin
                  if (phy.rxdet_ack) begin
                     if (res_all) begin
                        lanes_q <= phy.rxdet_result;
                        exit_q  <= 1'b1;
                        state_q <= DONE;
                     end else if (res_none) begin
                        state_q <= QUIET;
                     end else begin
                        lanes_q <= phy.rxdet_result;
                        state_q <= WAIT;
                     end
                  end
               end
               WAIT: begin
                  if (timer_expire)
                     state_q <= ACTIVE2;
               end
               ACTIVE2: begin
                  // Second detect must reproduce the partial set exactly.
                  if (phy.rxdet_ack) begin
                     if (phy.rxdet_result == lanes_q) begin
                        exit_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        lanes_q <= '0;
                        state_q <= QUIET;
                     end
                  end
               end
               DONE: ;
               default: begin
                  state_q <= QUIET;
                  lanes_q <= '0;
               end
            endcase
         end
      end
   end

   assign phy.rxdet_req           = (state_q == ACTIVE) || (state_q == ACTIVE2);
   assign lanes_w_detected_load_o = lanes_q;
   assign detect_exit_polling_o   = exit_q;
   assign detect_state_o          = state_q;
endmodule

// File: tb/tb_control_detect.sv
// Directed bench for control_detect with a cycle-level reference model.
module tb_control_detect;
   localparam int T = 16;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b1;
   logic [L-1:0] lanes;
   logic         exit_p;
   logic [2:0]   st;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   control_detect_if #(.NUM_LANES(L)) phy_if ();

   control_detect #(.NUM_LANES(L), .TIMEOUT_CYC(T)) dut (
      .clk_i                   (clk),
      .rst_ni                  (rst_n),
      .detect_en_i             (en),
      .phy                     (phy_if),
      .lanes_w_detected_load_o (lanes),
      .detect_exit_polling_o   (exit_p),
      .detect_state_o          (st)
   );

   always #5 clk = ~clk;

   // Reference model: state number, cycles spent counting, captured lanes, pulse.
   int       m_st;
   int       m_age;
   bit [L-1:0] m_lanes;
   bit       m_exit;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0; m_age <= 0; m_lanes <= '0; m_exit <= 1'b0;
      end else begin
         m_exit <= 1'b0;
         if (!en) begin
            m_st <= 0; m_age <= 0; m_lanes <= '0;
         end else if (m_st == 0) begin
            if (phy_if.rx_elec_idle != 4'b1111 || m_age == T - 1) begin
               m_st <= 1; m_age <= 0;
            end else m_age <= m_age + 1;
         end else if (m_st == 1) begin
            if (phy_if.rxdet_ack) begin
               if (phy_if.rxdet_result == 4'b1111) begin
                  m_lanes <= phy_if.rxdet_result; m_exit <= 1'b1; m_st <= 4;
               end else if (phy_if.rxdet_result == 4'b0000) m_st <= 0;
               else begin
                  m_lanes <= phy_if.rxdet_result; m_st <= 2;
               end
            end
         end else if (m_st == 2) begin
            if (m_age == T - 1) begin
               m_st <= 3; m_age <= 0;
            end else m_age <= m_age + 1;
         end else if (m_st == 3) begin
            if (phy_if.rxdet_ack) begin
               if (phy_if.rxdet_result == m_lanes) begin
                  m_exit <= 1'b1; m_st <= 4;
               end else begin
                  m_lanes <= '0; m_st <= 0;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         chk("cmp_state", int'(st), m_st);
         chk("cmp_req", int'(phy_if.rxdet_req), int'(m_st == 1 || m_st == 3));
         chk("cmp_lanes", int'(lanes), int'(m_lanes));
         chk("cmp_exit", int'(exit_p), int'(m_exit));
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic wait_req(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (phy_if.rxdet_req) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_ack(input logic [L-1:0] r);
      phy_if.rxdet_ack = 1'b1; phy_if.rxdet_result = r;
      step();
      phy_if.rxdet_ack = 1'b0; phy_if.rxdet_result = '0;
   endtask

   task automatic pulse_dis();
      en = 1'b0; step(); en = 1'b1;
   endtask

   int n;

   initial begin
      phy_if.rxdet_ack = 1'b0;
      phy_if.rxdet_result = '0;
      phy_if.rx_elec_idle = 4'b1111;
      step(); step();
      rst_n = 1'b1; chk_on = 1'b1;
      wait_req(n);
      chk("init_req_rise", n, T);
      $display("[TB] init reset release: req after %0d cycles", n);

      // Reset mid-ACTIVE
      step();
      rst_n = 1'b0; #1;
      chk("rst_state", int'(st), 0);
      chk("rst_req", int'(phy_if.rxdet_req), 0);
      chk("rst_lanes", int'(lanes), 0);
      chk("rst_exit", int'(exit_p), 0);
      step(); rst_n = 1'b1;
      wait_req(n);
      chk("rst_req_rise", n, 16);
      $display("[TB] reset mid-active: req after %0d cycles", n);

      // Full detect
      do_ack(4'b1111);
      chk("full_exit", int'(exit_p), 1);
      chk("full_lanes", int'(lanes), 15);
      chk("full_state", int'(st), 4);
      step(); step(); step();
      chk("full_exit_gone", int'(exit_p), 0);
      chk("full_hold", int'(st), 4);
      pulse_dis();
      chk("full_to_quiet", int'(st), 0);
      $display("[TB] full detect: lanes=%b", 4'b1111);

      // Idle exit at QUIET cycle 3
      step(); step(); step();
      phy_if.rx_elec_idle = 4'b1101;
      step();
      phy_if.rx_elec_idle = 4'b1111;
      chk("idle_state", int'(st), 1);
      chk("idle_req", int'(phy_if.rxdet_req), 1);
      $display("[TB] idle exit: state=%0d", st);

      // Partial match
      do_ack(4'b0011);
      chk("pm_wait", int'(st), 2);
      wait_req(n);
      chk("pm_wait_len", n, 16);
      chk("pm_active2", int'(st), 3);
      do_ack(4'b0011);
      chk("pm_exit", int'(exit_p), 1);
      chk("pm_lanes", int'(lanes), 3);
      $display("[TB] partial match: wait=%0d lanes=%b", n, lanes);
      pulse_dis();

      // Partial mismatch, with a stray ack during WAIT
      wait_req(n);
      do_ack(4'b0011);
      step(); step();
      do_ack(4'b1111);
      chk("stray_ack_wait", int'(st), 2);
      wait_req(n);
      do_ack(4'b0001);
      chk("mm_state", int'(st), 0);
      chk("mm_lanes", int'(lanes), 0);
      chk("mm_exit", int'(exit_p), 0);
      $display("[TB] partial mismatch: state=%0d", st);

      // No receivers
      wait_req(n);
      chk("none_req_rise", n, 16);
      do_ack(4'b0000);
      chk("none_state", int'(st), 0);
      $display("[TB] none detected: state=%0d", st);

      // Abort coincident with full-detect ack
      wait_req(n);
      en = 1'b0;
      do_ack(4'b1111);
      chk("abort_state", int'(st), 0);
      chk("abort_exit", int'(exit_p), 0);
      chk("abort_req", int'(phy_if.rxdet_req), 0);
      en = 1'b1;
      step(); step();
      $display("[TB] abort: state=%0d exit=%0d", st, exit_p);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
